// File: rtl/cook_timer_if.sv
// Control and display bundle between time_setting and the cook_timer
// countdown engine; master drives the requests, slave answers with state.
interface cook_timer_if;
    logic [5:0] i_min;
    logic [5:0] i_sec;
    logic       i_start;
    logic       i_pause;
    logic       i_cancel;
    logic       i_door_open;
    logic [5:0] o_min;
    logic [5:0] o_sec;
    logic       o_run;
    logic [1:0] o_motor;
    logic       o_done;
    logic       o_buzzer;

    modport master (
        output i_min, i_sec, i_start, i_pause, i_cancel, i_door_open,
        input  o_min, o_sec, o_run, o_motor, o_done, o_buzzer
    );

    modport slave (
        input  i_min, i_sec, i_start, i_pause, i_cancel, i_door_open,
        output o_min, o_sec, o_run, o_motor, o_done, o_buzzer
    );
endinterface

// File: rtl/cook_timer.sv
// Cook timer countdown engine: 1 Hz min:sec countdown with pause, door
// interlock, cancel, +30 s quick-add, done pulse and timed buzzer.
module cook_timer #(
    parameter int TICK_CNT = 100_000_000,
    parameter int BUZZ_SEC = 3
) (
    input  logic         clk,
    input  logic         rst,
    cook_timer_if.slave  ifc
);
    localparam int TW = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
    localparam int BW = (BUZZ_SEC > 1) ? $clog2(BUZZ_SEC) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CNT - 1);
    localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_SEC - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    state_t        state_q;
    logic [5:0]    min_q;
    logic [5:0]    sec_q;
    logic [TW-1:0] tick_q;
    logic [BW-1:0] buzz_q;
    logic          run_q;
    logic [1:0]    motor_q;
    logic          done_q;
    logic          buzzer_q;

    logic          tick_end;
    logic [5:0]    ld_min;
    logic [5:0]    ld_sec;
    logic          ld_nz;
    logic [5:0]    dec_min;
    logic [5:0]    dec_sec;
    logic [6:0]    sec_sum;
    logic [5:0]    nx_min;
    logic [5:0]    nx_sec;
    logic          nx_zero;
    logic          start_ok;

    assign tick_end = (tick_q == TICK_LAST);
    assign start_ok = ifc.i_start && !ifc.i_door_open;

    always_comb begin
        ld_min  = (ifc.i_min > 6'd59) ? 6'd59 : ifc.i_min;
        ld_sec  = (ifc.i_sec > 6'd59) ? 6'd59 : ifc.i_sec;
        ld_nz   = (ld_min != 6'd0) || (ld_sec != 6'd0);
        dec_min = min_q;
        dec_sec = sec_q;
        if (tick_end) begin
            if (sec_q != 6'd0) begin
                dec_sec = sec_q - 6'd1;
            end else if (min_q != 6'd0) begin
                dec_min = min_q - 6'd1;
                dec_sec = 6'd59;
            end
        end
        // quick-add applies on top of this cycle's decrement
        sec_sum = {1'b0, dec_sec} + 7'd30;
        nx_min  = dec_min;
        nx_sec  = dec_sec;
        if (ifc.i_start) begin
            if (sec_sum <= 7'd59) begin
                nx_sec = sec_sum[5:0];
            end else if (dec_min == 6'd59) begin
                nx_min = 6'd59;
                nx_sec = 6'd59;
            end else begin
                nx_min = dec_min + 6'd1;
                nx_sec = dec_sec - 6'd30;
            end
        end
        nx_zero = (nx_min == 6'd0) && (nx_sec == 6'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            min_q    <= 6'd0;
            sec_q    <= 6'd0;
            tick_q   <= '0;
            buzz_q   <= '0;
            run_q    <= 1'b0;
            motor_q  <= 2'b00;
            done_q   <= 1'b0;
            buzzer_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ifc.i_cancel) begin
                state_q  <= IDLE;
                min_q    <= 6'd0;
                sec_q    <= 6'd0;
                tick_q   <= '0;
                buzz_q   <= '0;
                run_q    <= 1'b0;
                motor_q  <= 2'b00;
                buzzer_q <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start_ok && ld_nz) begin
                            min_q   <= ld_min;
                            sec_q   <= ld_sec;
                            tick_q  <= '0;
                            state_q <= RUN;
                            run_q   <= 1'b1;
                            motor_q <= 2'b01;
                        end
                    end
                    RUN: begin
                        if (ifc.i_door_open || ifc.i_pause) begin
                            state_q <= PAUSE;
                            run_q   <= 1'b0;
                            motor_q <= 2'b00;
                        end else begin
                            tick_q <= tick_end ? '0 : tick_q + TW'(1);
                            min_q  <= nx_min;
                            sec_q  <= nx_sec;
                            if (nx_zero) begin
                                state_q  <= DONE;
                                done_q   <= 1'b1;
                                buzzer_q <= 1'b1;
                                buzz_q   <= '0;
                                run_q    <= 1'b0;
                                motor_q  <= 2'b00;
                            end
                        end
                    end
                    PAUSE: begin
                        if (start_ok) begin
                            state_q <= RUN;
                            run_q   <= 1'b1;
                            motor_q <= 2'b01;
                        end
                    end
                    DONE: begin
                        if (start_ok) begin
                            state_q  <= IDLE;
                            buzzer_q <= 1'b0;
                            tick_q   <= '0;
                            buzz_q   <= '0;
                        end else if (tick_end) begin
                            tick_q <= '0;
                            if (buzz_q == BUZZ_LAST) begin
                                state_q  <= IDLE;
                                buzzer_q <= 1'b0;
                                buzz_q   <= '0;
                            end else begin
                                buzz_q <= buzz_q + BW'(1);
                            end
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ifc.o_min    = min_q;
    assign ifc.o_sec    = sec_q;
    assign ifc.o_run    = run_q;
    assign ifc.o_motor  = motor_q;
    assign ifc.o_done   = done_q;
    assign ifc.o_buzzer = buzzer_q;
endmodule

// File: tb/tb_cook_timer.sv
// Directed bench for cook_timer with TICK_CNT=10, BUZZ_SEC=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cook_timer;
    logic clk;
    logic rst;
    int   vecs;
    int   miss;

    cook_timer_if ifc ();

    cook_timer #(
        .TICK_CNT(10),
        .BUZZ_SEC(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ifc (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        ifc.i_start = 1'b1;
        step(1);
        ifc.i_start = 1'b0;
    endtask

    task automatic pulse_pause();
        ifc.i_pause = 1'b1;
        step(1);
        ifc.i_pause = 1'b0;
    endtask

    task automatic pulse_cancel();
        ifc.i_cancel = 1'b1;
        step(1);
        ifc.i_cancel = 1'b0;
    endtask

    task automatic load(input logic [5:0] m, input logic [5:0] s);
        ifc.i_min = m;
        ifc.i_sec = s;
    endtask

    initial begin
        vecs = 0;
        miss = 0;
        rst = 1'b0;
        ifc.i_min = 6'd0;
        ifc.i_sec = 6'd0;
        ifc.i_start = 1'b0;
        ifc.i_pause = 1'b0;
        ifc.i_cancel = 1'b0;
        ifc.i_door_open = 1'b0;
        step(3);
        chk("rst_min", 16'(ifc.o_min), 16'd0);
        chk("rst_sec", 16'(ifc.o_sec), 16'd0);
        chk("rst_run", 16'(ifc.o_run), 16'd0);
        chk("rst_motor", 16'(ifc.o_motor), 16'd0);
        chk("rst_done", 16'(ifc.o_done), 16'd0);
        chk("rst_buzz", 16'(ifc.o_buzzer), 16'd0);
        rst = 1'b1;
        step(2);

        // 1: 00:03 full countdown, done pulse, 20-clk buzzer
        load(6'd0, 6'd3);
        pulse_start();
        chk("t1_run", 16'(ifc.o_run), 16'd1);
        chk("t1_motor", 16'(ifc.o_motor), 16'd1);
        chk("t1_sec3", 16'(ifc.o_sec), 16'd3);
        step(9);
        chk("t1_sec3_hold", 16'(ifc.o_sec), 16'd3);
        step(1);
        chk("t1_sec2", 16'(ifc.o_sec), 16'd2);
        step(10);
        chk("t1_sec1", 16'(ifc.o_sec), 16'd1);
        step(9);
        chk("t1_nodone", 16'(ifc.o_done), 16'd0);
        step(1);
        chk("t1_sec0", 16'(ifc.o_sec), 16'd0);
        chk("t1_done", 16'(ifc.o_done), 16'd1);
        chk("t1_run0", 16'(ifc.o_run), 16'd0);
        chk("t1_motor0", 16'(ifc.o_motor), 16'd0);
        chk("t1_buzz", 16'(ifc.o_buzzer), 16'd1);
        step(1);
        chk("t1_done_1cyc", 16'(ifc.o_done), 16'd0);
        chk("t1_buzz_on", 16'(ifc.o_buzzer), 16'd1);
        step(18);
        chk("t1_buzz_last", 16'(ifc.o_buzzer), 16'd1);
        step(1);
        chk("t1_buzz_off", 16'(ifc.o_buzzer), 16'd0);
        chk("t1_idle_run", 16'(ifc.o_run), 16'd0);

        // 2: minute borrow, zero-time start, input clamp
        load(6'd1, 6'd0);
        pulse_start();
        chk("t2_min1", 16'(ifc.o_min), 16'd1);
        step(10);
        chk("t2_min0", 16'(ifc.o_min), 16'd0);
        chk("t2_sec59", 16'(ifc.o_sec), 16'd59);
        pulse_cancel();
        load(6'd0, 6'd0);
        pulse_start();
        chk("t2_zero_run", 16'(ifc.o_run), 16'd0);
        step(3);
        chk("t2_zero_run_hold", 16'(ifc.o_run), 16'd0);
        load(6'd63, 6'd60);
        pulse_start();
        chk("t2_clamp_min", 16'(ifc.o_min), 16'd59);
        chk("t2_clamp_sec", 16'(ifc.o_sec), 16'd59);
        pulse_cancel();

        // 3: pause freezes the tick counter at 3
        load(6'd0, 6'd5);
        pulse_start();
        step(13);
        chk("t3_sec4", 16'(ifc.o_sec), 16'd4);
        pulse_pause();
        chk("t3_p_run", 16'(ifc.o_run), 16'd0);
        chk("t3_p_motor", 16'(ifc.o_motor), 16'd0);
        step(50);
        chk("t3_p_hold", 16'(ifc.o_sec), 16'd4);
        pulse_pause();
        chk("t3_p_ign", 16'(ifc.o_run), 16'd0);
        pulse_start();
        chk("t3_resume", 16'(ifc.o_run), 16'd1);
        step(6);
        chk("t3_pre_dec", 16'(ifc.o_sec), 16'd4);
        step(1);
        chk("t3_dec", 16'(ifc.o_sec), 16'd3);
        pulse_cancel();

        // 4: door interlock
        load(6'd0, 6'd10);
        pulse_start();
        step(2);
        ifc.i_door_open = 1'b1;
        step(1);
        chk("t4_door_run", 16'(ifc.o_run), 16'd0);
        chk("t4_door_motor", 16'(ifc.o_motor), 16'd0);
        pulse_start();
        chk("t4_start_ign", 16'(ifc.o_run), 16'd0);
        ifc.i_door_open = 1'b0;
        step(1);
        chk("t4_closed_hold", 16'(ifc.o_run), 16'd0);
        pulse_start();
        chk("t4_resume_run", 16'(ifc.o_run), 16'd1);
        chk("t4_resume_motor", 16'(ifc.o_motor), 16'd1);
        chk("t4_sec", 16'(ifc.o_sec), 16'd10);
        pulse_cancel();

        // 5: quick-add carry, saturation, add on terminal tick
        load(6'd0, 6'd45);
        pulse_start();
        pulse_start();
        chk("t5_carry_min", 16'(ifc.o_min), 16'd1);
        chk("t5_carry_sec", 16'(ifc.o_sec), 16'd15);
        pulse_cancel();
        load(6'd59, 6'd50);
        pulse_start();
        pulse_start();
        chk("t5_sat_min", 16'(ifc.o_min), 16'd59);
        chk("t5_sat_sec", 16'(ifc.o_sec), 16'd59);
        pulse_cancel();
        load(6'd0, 6'd1);
        pulse_start();
        step(9);
        pulse_start();
        chk("t5_term_sec", 16'(ifc.o_sec), 16'd30);
        chk("t5_term_done", 16'(ifc.o_done), 16'd0);
        chk("t5_term_run", 16'(ifc.o_run), 16'd1);
        pulse_cancel();

        // 6: cancel mid-run, reset during DONE
        load(6'd0, 6'd7);
        pulse_start();
        step(5);
        pulse_cancel();
        chk("t6_c_sec", 16'(ifc.o_sec), 16'd0);
        chk("t6_c_run", 16'(ifc.o_run), 16'd0);
        chk("t6_c_done", 16'(ifc.o_done), 16'd0);
        step(15);
        chk("t6_c_idle", 16'(ifc.o_sec), 16'd0);
        chk("t6_c_buzz", 16'(ifc.o_buzzer), 16'd0);
        load(6'd0, 6'd1);
        pulse_start();
        step(10);
        chk("t6_done", 16'(ifc.o_done), 16'd1);
        chk("t6_buzz", 16'(ifc.o_buzzer), 16'd1);
        step(1);
        rst = 1'b0;
        #1;
        chk("t6_rst_buzz", 16'(ifc.o_buzzer), 16'd0);
        chk("t6_rst_done", 16'(ifc.o_done), 16'd0);
        step(1);
        rst = 1'b1;
        step(2);
        chk("t6_post_run", 16'(ifc.o_run), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
